// File: rtl/dmem_write_buffer.sv
// Data-memory front end: buffers core stores in a circular FIFO, drains them to a
// handshaked memory port in the background and forwards buffered data to loads.
module dmem_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemWriteM,
  input  logic                   MemReadM,
  input  logic [ADDR_W-1:0]      AddrM,
  input  logic [DATA_W-1:0]      WriteDataM,
  output logic [DATA_W-1:0]      ReadDataM,
  output logic                   MemStall,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_ack,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [$clog2(DEPTH):0] buf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, DRAIN, READ, RDONE} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WA_W-1:0]   wa_q [DEPTH];
  logic [DATA_W-1:0] wd_q [DEPTH];
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [WA_W-1:0]   load_wa;
  logic              full, empty, enq, pop;
  logic              hit, load_miss;
  logic [DEPTH-1:0]  match;
  logic [PTR_W-1:0]  age [DEPTH];
  logic [PTR_W-1:0]  best_age;
  logic [DATA_W-1:0] fwd_data;
  logic              addr_lsb_unused;

  assign load_wa         = AddrM[ADDR_W-1:2];
  assign addr_lsb_unused = ^AddrM[1:0];
  assign full            = (count_q == CNT_W'(DEPTH));
  assign empty           = (count_q == '0);
  // A store presented together with a load is dropped.
  assign enq             = MemWriteM & ~MemReadM & ~full;
  assign pop             = (state_q == DRAIN) & mem_ack;
  assign load_miss       = MemReadM & ~hit;

  // Age 0 is the head (oldest); an entry is live when its age is below the count.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign age[gi]   = PTR_W'(gi) - head_q;
      assign match[gi] = ({1'b0, age[gi]} < count_q) && (wa_q[gi] == load_wa);
    end
  endgenerate

  always_comb begin
    hit      = 1'b0;
    best_age = '0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i] && (!hit || (age[i] > best_age))) begin
        hit      = 1'b1;
        best_age = age[i];
        fwd_data = wd_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      wa_q[tail_q] <= load_wa;
      wd_q[tail_q] <= WriteDataM;
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(enq);
    count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // A load miss cannot alias a buffered store, so it may overtake the drain.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (load_miss) begin
          state_d    = READ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {load_wa, 2'b00};
        end else if (!empty) begin
          state_d     = DRAIN;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {wa_q[head_q], 2'b00};
          mem_wdata_d = wd_q[head_q];
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      READ: begin
        if (mem_ack) begin
          state_d   = RDONE;
          mem_req_d = 1'b0;
          rdata_d   = mem_rdata;
        end
      end
      RDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    MemStall  = (MemWriteM & full) | (MemReadM & ~hit & (state_q != RDONE));
    ReadDataM = (MemReadM & hit) ? fwd_data : rdata_q;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign buf_count = count_q;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Bench for dmem_write_buffer: architectural memory model plus a FIFO of pending
// stores; a monitor checks every memory handshake and every completed load.
module tb_dmem_write_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int OP_NOP = 0;
  localparam int OP_ST  = 1;
  localparam int OP_LD  = 2;

  logic              clk;
  logic              reset;
  logic              MemWriteM, MemReadM;
  logic [ADDR_W-1:0] AddrM;
  logic [DATA_W-1:0] WriteDataM, ReadDataM;
  logic              MemStall, mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [$clog2(DEPTH):0] buf_count;

  dmem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .AddrM(AddrM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
    .MemStall(MemStall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .buf_count(buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } st_t;

  st_t         wb_q[$];       // stores accepted but not yet written, oldest first
  logic [31:0] read_exp[$];   // addresses of outstanding load misses
  logic [31:0] load_exp[$];   // expected data of issued loads
  logic [31:0] arch [logic [31:0]];  // program-order memory image
  logic [31:0] phys [logic [31:0]];  // what the memory port has actually received
  int vectors = 0;
  int errors  = 0;
  bit ack_hold = 1'b0;
  bit expect_read_first = 1'b0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] arch_read(input logic [31:0] k);
    if (arch.exists(k)) return arch[k];
    return init_val(k);
  endfunction

  function automatic logic [31:0] phys_read(input logic [31:0] k);
    if (phys.exists(k)) return phys[k];
    return init_val(k);
  endfunction

  function automatic bit model_hit(input logic [31:0] k);
    foreach (wb_q[i]) if (wb_q[i].a == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    vectors++;
    errors++;
    $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Memory port responder: acks each request after 0..3 cycles unless held.
  initial begin
    int wait_cnt;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!reset) begin
        wait_cnt = $urandom_range(0, 3);
      end else if (mem_req && !ack_hold) begin
        if (wait_cnt == 0) begin
          mem_ack = 1'b1;
          if (mem_we) phys[{mem_addr[31:2], 2'b00}] = mem_wdata;
          else        mem_rdata = phys_read({mem_addr[31:2], 2'b00});
          wait_cnt = $urandom_range(0, 3);
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Monitor: compares memory handshakes and completed loads against the scoreboard.
  initial begin
    bit pop_pend;
    forever begin
      @(negedge clk);
      pop_pend = 1'b0;
      if (reset) begin
        if (mem_req && mem_ack) begin
          if (mem_we) begin
            if (wb_q.size() == 0) fail("drain_unexpected", 1, 0);
            else begin
              check("drain_addr", mem_addr, wb_q[0].a);
              check("drain_data", mem_wdata, wb_q[0].d);
              pop_pend = 1'b1;
            end
          end else begin
            if (read_exp.size() == 0) fail("read_unexpected", 1, 0);
            else check("read_addr", mem_addr, read_exp.pop_front());
          end
        end
        if (MemReadM && !MemStall) begin
          if (load_exp.size() == 0) fail("load_unexpected", 1, 0);
          else check("load_data", ReadDataM, load_exp.pop_front());
        end
      end
      @(posedge clk);
      if (pop_pend) void'(wb_q.pop_front());
    end
  end

  task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] data);
    int cyc;
    bit done;
    bit exp_stall;
    logic [31:0] key;
    st_t ent;
    key = {addr[31:2], 2'b00};
    @(posedge clk); #1;
    MemWriteM  = (kind == OP_ST);
    MemReadM   = (kind == OP_LD);
    AddrM      = addr;
    WriteDataM = data;
    if (kind == OP_LD) load_exp.push_back(arch_read(key));
    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      check("buf_count", buf_count, wb_q.size());
      case (kind)
        OP_ST: begin
          exp_stall = (wb_q.size() == DEPTH);
          check("store_stall", MemStall, exp_stall);
          if (!exp_stall) begin
            ent.a = key;
            ent.d = data;
            wb_q.push_back(ent);
            arch[key] = data;
            done = 1'b1;
          end
        end
        OP_LD: begin
          if (cyc == 1) begin
            exp_stall = !model_hit(key);
            check("load_stall", MemStall, exp_stall);
            if (exp_stall) read_exp.push_back(key);
          end
          if (cyc == 2 && expect_read_first) begin
            check("read_first_req", mem_req, 1);
            check("read_first_we", mem_we, 0);
            check("read_first_addr", mem_addr, key);
          end
          if (!MemStall) done = 1'b1;
        end
        default: begin
          check("idle_stall", MemStall, 0);
          done = 1'b1;
        end
      endcase
      if (cyc >= 3) ack_hold = 1'b0;
      if (!done && cyc >= 60) begin
        fail("op_timeout", cyc, 60);
        done = 1'b1;
      end
    end
    $display("op=%0d addr=0x%08h data=0x%08h cycles=%0d count=%0d", kind, addr, data, cyc, buf_count);
  endtask

  task automatic wait_empty();
    int cyc;
    @(posedge clk); #1;
    MemWriteM = 1'b0;
    MemReadM  = 1'b0;
    cyc = 0;
    ack_hold = 1'b0;
    while (wb_q.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (wb_q.size() != 0) fail("drain_timeout", wb_q.size(), 0);
    else check("drain_empty_count", buf_count, 0);
  endtask

  task automatic check_reset_state();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_read_data", ReadDataM, 0);
    check("rst_buf_count", buf_count, 0);
    check("rst_stall", MemStall, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    MemWriteM = 1'b0; MemReadM = 1'b0; AddrM = '0; WriteDataM = '0;
    repeat (3) @(negedge clk);
    check_reset_state();
    reset = 1'b1;

    // Single store drained to memory.
    do_op(OP_ST, 32'h40, 32'hDEAD_BEEF);
    wait_empty();

    // Fill the buffer with the port stalled; the fifth store must wait.
    ack_hold = 1'b1;
    for (int i = 0; i < 5; i++) do_op(OP_ST, 32'(i * 4), 32'h1000 + 32'(i));
    wait_empty();

    // Youngest of two matching stores is forwarded.
    ack_hold = 1'b1;
    do_op(OP_ST, 32'h80, 32'h11);
    do_op(OP_ST, 32'h80, 32'h22);
    do_op(OP_LD, 32'h80, 32'h0);
    wait_empty();

    // A load miss overtakes a pending drain.
    phys[32'h200] = 32'hCAFE_F00D;
    arch[32'h200] = 32'hCAFE_F00D;
    ack_hold = 1'b1;
    do_op(OP_ST, 32'h300, 32'h3333);
    expect_read_first = 1'b1;
    do_op(OP_LD, 32'h200, 32'h0);
    expect_read_first = 1'b0;
    wait_empty();

    // Reset while draining discards the buffer.
    ack_hold = 1'b1;
    for (int i = 0; i < 3; i++) do_op(OP_ST, 32'h400 + 32'(i * 4), 32'hA0 + 32'(i));
    @(posedge clk); #1;
    MemWriteM = 1'b0;
    @(negedge clk);
    check("pre_rst_req", mem_req, 1);
    check("pre_rst_count", buf_count, 3);
    reset = 1'b0;
    #1;
    check("midrst_mem_req", mem_req, 0);
    check("midrst_buf_count", buf_count, 0);
    wb_q.delete();
    read_exp.delete();
    load_exp.delete();
    arch = phys;
    ack_hold = 1'b0;
    @(negedge clk);
    check_reset_state();
    reset = 1'b1;
    do_op(OP_ST, 32'h404, 32'h5555_AAAA);
    wait_empty();
    do_op(OP_LD, 32'h400, 32'h0);

    // Wrap the pointers, then forward across the wrap point.
    for (int i = 0; i < 9; i++) begin
      do_op(OP_ST, 32'h500 + 32'(i * 4), 32'h9000 + 32'(i));
      wait_empty();
    end
    ack_hold = 1'b1;
    do_op(OP_ST, 32'h600, 32'h0000_00AA);
    do_op(OP_ST, 32'h604, 32'h0000_00BB);
    do_op(OP_ST, 32'h608, 32'h0000_00CC);
    do_op(OP_ST, 32'h600, 32'h0000_00DD);
    do_op(OP_LD, 32'h600, 32'h0);
    do_op(OP_LD, 32'h508, 32'h0);
    wait_empty();

    // Random mix of stores, loads and idle cycles over a small address window.
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      a = 32'h1000 + 32'($urandom_range(0, 7) * 4);
      if (r < 40)      do_op(OP_ST, a, $urandom);
      else if (r < 75) do_op(OP_LD, a, 32'h0);
      else             do_op(OP_NOP, a, 32'h0);
    end
    wait_empty();
    check("read_exp_left", read_exp.size(), 0);
    check("load_exp_left", load_exp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dmem_write_buffer.md
Name: dmem_write_buffer

Overview:
Data-memory interface between the pipelined core's Memory stage and a handshaked data SRAM/bus port. It holds core stores in a circular write buffer and drains them to memory in the background. Loads that hit a buffered store get store-to-load forwarding from the buffer; load misses issue a memory read. The core is stalled only when the buffer is full or a load miss is outstanding.

Parameters:
DEPTH, 4, number of write-buffer entries (power of 2, ≥2)
ADDR_W, 32, byte address width
DATA_W, 32, data word width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
MemWriteM  in  1  core store request (Memory stage)
MemReadM  in  1  core load request (Memory stage)
AddrM  in  ADDR_W  byte address (ALU result); word-aligned, bits [1:0] ignored
WriteDataM  in  DATA_W  store data
ReadDataM  out  DATA_W  load data to the core
MemStall  out  1  freeze request to the core's hazard logic
mem_req  out  1  memory request valid (registered)
mem_we  out  1  1=write, 0=read (registered)
mem_addr  out  ADDR_W  memory address (registered)
mem_wdata  out  DATA_W  memory write data (registered)
mem_ack  in  1  memory completion; one-cycle pulse
mem_rdata  in  DATA_W  read data, valid with mem_ack when mem_we=0
buf_count  out  $clog2(DEPTH)+1  occupied entries, for debug

Behaviour:
- Reset (reset=0, async): head/tail pointers=0, count=0, state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, read-data register=0, ReadDataM=0.
- A reset during a transaction abandons it. Buffered stores are lost and mem_req drops immediately.
- Buffer: circular FIFO; tail/head wrap modulo DEPTH; full = (count==DEPTH); empty = (count==0).
- Store: MemWriteM=1 and not full -> enqueue {AddrM[ADDR_W-1:2], WriteDataM} at the clock edge. MemStall=0 for the store.
- Store when full -> MemStall=1 (combinational) and no enqueue. The core holds the request; it is accepted on the first edge at which the registered count < DEPTH.
- Enqueue and pop on the same edge -> count unchanged, both pointers advance.
- Forwarding hit: MemReadM=1 and word address matches any valid entry. ReadDataM = data of the youngest matching entry, combinational, MemStall=0.
- A hit on the entry currently being drained is still forwarded; entries leave the buffer only on mem_ack.
- Load miss: MemStall=1 until the RDONE cycle. The core holds MemReadM/AddrM stable while stalled.
- FSM states: IDLE, DRAIN, READ, RDONE.
- IDLE transitions:
  - Load miss pending -> READ: mem_req=1, mem_we=0, mem_addr={word addr,2'b00}. Reads take priority over draining; this is safe because a miss has no address overlap with the buffer.
  - Otherwise, if not empty -> DRAIN: mem_req=1, mem_we=1, mem_addr/mem_wdata from the head entry.
  - Otherwise stay in IDLE with mem_req=0.
- DRAIN: mem_* held stable until mem_ack. On the mem_ack edge: pop head, mem_req=0, go to IDLE. This gives a minimum of 2 cycles per drained store.
- READ: mem_* held stable until mem_ack. On the mem_ack edge: capture mem_rdata into the read-data register, mem_req=0, go to RDONE.
- RDONE: lasts one cycle. ReadDataM = read-data register, MemStall=0. Then go to IDLE.
- MemStall = (MemWriteM & full) | (MemReadM & ~hit & state!=RDONE).
- MemWriteM and MemReadM asserted together is illegal; the store is ignored.
- When no load is active, ReadDataM = read-data register.
- mem_ack outside DRAIN/READ is ignored.

Test Plan:
1. Reset. Store 0xDEADBEEF to 0x40, mem_ack 2 cycles after req -> mem_req/mem_we=1 with mem_addr=0x40, mem_wdata=0xDEADBEEF; buf_count goes 1->0 on ack; MemStall never asserted.
2. Hold mem_ack=0. Issue 5 stores to 0x00,0x04,0x08,0x0C,0x10 -> MemStall=1 on the 5th with buf_count=4. Pulse ack -> 5th store accepted on the next edge. Memory sees the writes in address order.
3. Store 0x11 then 0x22 to 0x80, then load 0x80 with no ack -> ReadDataM=0x22 in the same cycle, MemStall=0.
4. Load miss to 0x200 with buffer non-empty, mem_rdata=0xCAFEF00D acked after 3 cycles -> READ issued before DRAIN; MemStall=1 until RDONE; ReadDataM=0xCAFEF00D in RDONE.
5. Pull reset low mid-DRAIN with buf_count=3 -> mem_req=0 immediately; buf_count=0, state IDLE. A subsequent store drains normally.
6. Address wrap: 9 store/drain pairs with DEPTH=4 -> pointers wrap twice, no data corruption; a forwarding hit across the wrap boundary returns the youngest entry.
